mont_mul_serial: RTL and testbench
==================================

Name: mont_mul_serial

Overview:
- Bit-serial radix-2 Montgomery multiplier. Computes result = a * b * 2^-DATA_LENGTH mod n.
- Consumes the R mod n and R^2 mod n constants produced by the constant-generation block (its downstream end):
  - b = R^2 mod n converts an operand into the Montgomery domain.
  - b = 1 converts it back out.
- Sits between constant generation and the modular-exponentiation controller, which sequences it through start/done.

Parameters:
- DATA_LENGTH, 1024, operand/modulus width in bits. Also sets the number of iterations; R = 2^DATA_LENGTH.
- CNT_W, 11, iteration counter width. Must satisfy 2^CNT_W > DATA_LENGTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE.
- a  in  DATA_LENGTH  multiplicand. Requirement: a < n.
- b  in  DATA_LENGTH  multiplier. Requirement: b < n; pass R^2 mod n or 1 for domain conversion.
- n  in  DATA_LENGTH  modulus. Must be odd.
- busy  out  1  high from the cycle after start is accepted until the done cycle inclusive.
- result  out  DATA_LENGTH  registered product. Held until the next completion.
- done  out  1  single-cycle completion pulse.
- n_err  out  1  valid with done; high when the captured n was even.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, n_err=0, result=0; internal accumulator and counter cleared. An operation in flight is discarded, no done is issued, and new starts are accepted on the first edge after rst deasserts.
- States:
  - IDLE:
    - done=0.
    - On start=1: capture a, b and n into a_reg, b_reg and n_reg; clear S (DATA_LENGTH+2 bits); clear cnt.
    - If n[0]=0 go to FIX with err set; otherwise go to ITER.
  - ITER: one bit per cycle, LSB of a_reg first.
    - S1 = S + (a_reg[0] ? b_reg : 0).
    - S2 = S1 + (S1[0] ? n_reg : 0).
    - S <= S2 >> 1; a_reg <= a_reg >> 1; cnt++.
    - After DATA_LENGTH iterations (cnt==DATA_LENGTH-1 on the current cycle) go to FIX.
  - FIX:
    - result <= (S >= n_reg) ? S - n_reg : S[DATA_LENGTH-1:0].
    - If err: result <= 0, n_err <= 1.
    - done <= 1; go to IDLE.
- Timing:
  - Start accepted at edge k. ITER runs on edges k+1 … k+DATA_LENGTH. FIX is edge k+DATA_LENGTH+1, and done is high for exactly that one following cycle.
  - Latency is DATA_LENGTH+2 edges from start to done. The even-n path takes 2 edges.
- Width rules:
  - S never exceeds 2n-1 after each shift, so DATA_LENGTH+2 bits suffice with no overflow.
  - Final result < n.
- Handshake and edge cases:
  - start while busy is ignored (not queued).
  - start asserted in the same cycle done is high is accepted, because the state is already IDLE. Back-to-back operations have no bubble beyond FIX.
  - Operands are captured at start; a, b and n may change freely afterwards.
  - n_err is cleared on the next accepted start.
  - a or b ≥ n: no check is made. The result is congruent mod n but not guaranteed < n.
  - a=0 or b=0 gives result 0.

Decomposition:
- Shared package holds:
  - DATA_LENGTH and the derived T_DATA.
  - State encoding: IDLE=2'b00, ITER=2'b01, FIX=2'b10, with 2'b11 unused and recovering to IDLE.
  - The counter width constant.
- One natural sub-module: mont_iter_step. It is the combinational S1/S2/shift datapath for one iteration, and is reusable for a future radix-4 or unrolled variant.
- The FSM, operand registers and final subtract stay in the top module.

Test Plan (DATA_LENGTH=8, CNT_W=4, n=239, so R mod n=17 and R^2 mod n=50):
- To domain: a=5, b=50, start pulse → done exactly 10 edges after start; result=85; n_err=0; busy high for 9 cycles.
- From domain: a=85, b=1 → result=5. Then a=238, b=238 → result=225 (R^-1 mod 239).
- Zero and even modulus:
  - a=0, b=123 → result=0.
  - n=240 → done after 2 edges; n_err=1; result=0.
  - Next valid start clears n_err.
- Handshake:
  - Start pulses during busy are ignored: exactly one done, result=85.
  - start held high through done launches the next operation immediately: second done 10 edges later.
- Reset mid-operation:
  - rst asserted 4 cycles after start (async, between edges) → busy, done and result go to 0 immediately; no done follows.
  - A fresh start after release gives a correct result (85).

Source files
------------

// File: rtl/mont_mul_serial_pkg.sv
// mont_mul_serial_pkg
// Shared definitions for the bit-serial Montgomery multiplier:
//   - default operand width and iteration-counter width
//   - default-width operand type
//   - controller state encoding (2'b11 is unused and recovers to StIdle)
package mont_mul_serial_pkg;

  localparam int unsigned DEF_DATA_LENGTH = 1024;
  // Counter must satisfy 2**DEF_CNT_W > DEF_DATA_LENGTH.
  localparam int unsigned DEF_CNT_W = 11;

  typedef logic [DEF_DATA_LENGTH-1:0] t_data;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StIter = 2'b01,
    StFix  = 2'b10
  } t_state;

endpackage

// File: rtl/mont_mul_serial_if.sv
// mont_mul_serial_if
// Request/response bundle between the exponentiation controller (master)
// and the Montgomery multiplier (slave).
//   start  : request, sampled only while the multiplier is idle
//   a, b, n: multiplicand, multiplier, odd modulus
//   busy   : operation in flight (through the done cycle)
//   result : registered product, held until the next completion
//   done   : single-cycle completion pulse
//   n_err  : valid with done, set when the captured modulus was even
interface mont_mul_serial_if
  import mont_mul_serial_pkg::*;
#(
  parameter int unsigned DATA_LENGTH = DEF_DATA_LENGTH
);

  logic                   start;
  logic [DATA_LENGTH-1:0] a;
  logic [DATA_LENGTH-1:0] b;
  logic [DATA_LENGTH-1:0] n;
  logic                   busy;
  logic [DATA_LENGTH-1:0] result;
  logic                   done;
  logic                   n_err;

  modport master (
    output start, a, b, n,
    input  busy, result, done, n_err
  );

  modport slave (
    input  start, a, b, n,
    output busy, result, done, n_err
  );

endinterface

// File: rtl/mont_iter_step.sv
// mont_iter_step
// Combinational datapath for one radix-2 Montgomery iteration:
//   S1 = S + (a_bit ? b : 0)
//   S2 = S1 + (S1[0] ? n : 0)   (makes S2 even so the shift is exact)
//   o_s = S2 >> 1
// Ports:
//   i_s     : running accumulator (DATA_LENGTH+2 bits)
//   i_a_bit : current multiplicand bit
//   i_b     : multiplier
//   i_n     : odd modulus
//   o_s     : next accumulator
module mont_iter_step #(
  parameter int unsigned DATA_LENGTH = 1024
) (
  input  logic [DATA_LENGTH+1:0] i_s,
  input  logic                   i_a_bit,
  input  logic [DATA_LENGTH-1:0] i_b,
  input  logic [DATA_LENGTH-1:0] i_n,
  output logic [DATA_LENGTH+1:0] o_s
);

  // One spare bit over the accumulator so out-of-range operands cannot wrap
  // before the shift.
  logic [DATA_LENGTH+2:0] w_s1;
  logic [DATA_LENGTH+2:0] w_s2;

  always_comb begin
    w_s1 = {1'b0, i_s} + (i_a_bit ? {3'b000, i_b} : '0);
    w_s2 = w_s1 + (w_s1[0] ? {3'b000, i_n} : '0);
    o_s  = (DATA_LENGTH + 2)'(w_s2 >> 1);
  end

endmodule

// File: rtl/mont_mul_serial.sv
// mont_mul_serial
// Bit-serial radix-2 Montgomery multiplier: result = a * b * 2^-DATA_LENGTH mod n.
// One multiplicand bit per cycle (LSB first), then a single conditional
// subtract. An even modulus skips the iterations and reports n_err.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : mont_mul_serial_if slave (start/a/b/n in; busy/result/done/n_err out)
module mont_mul_serial
  import mont_mul_serial_pkg::*;
#(
  parameter int unsigned DATA_LENGTH = DEF_DATA_LENGTH,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  mont_mul_serial_if.slave        bus
);

  t_state                 r_state;
  t_state                 w_state_next;

  logic [DATA_LENGTH-1:0] r_a;
  logic [DATA_LENGTH-1:0] r_b;
  logic [DATA_LENGTH-1:0] r_n;
  logic [DATA_LENGTH+1:0] r_s;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_err;

  logic [DATA_LENGTH-1:0] r_result;
  logic                   r_done;
  logic                   r_n_err;
  logic                   r_busy;

  logic [DATA_LENGTH+1:0] w_s_step;
  logic                   w_last_iter;
  logic                   w_s_ge_n;
  logic [DATA_LENGTH-1:0] w_fix;

  mont_iter_step #(
    .DATA_LENGTH (DATA_LENGTH)
  ) u_iter_step (
    .i_s     (r_s),
    .i_a_bit (r_a[0]),
    .i_b     (r_b),
    .i_n     (r_n),
    .o_s     (w_s_step)
  );

  assign w_last_iter = (r_cnt == CNT_W'(DATA_LENGTH - 1));

  // Final reduction: S < 2n, so one conditional subtract lands in [0, n).
  always_comb begin
    w_s_ge_n = (r_s >= {2'b00, r_n});
    w_fix    = DATA_LENGTH'(w_s_ge_n ? (r_s - {2'b00, r_n}) : r_s);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_next = bus.n[0] ? StIter : StFix;
        end
      end
      StIter: begin
        if (w_last_iter) begin
          w_state_next = StFix;
        end
      end
      StFix: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_n      <= '0;
      r_s      <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_n_err  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Lags the state by one cycle so busy covers the done cycle.
      r_busy <= (r_state != StIdle);
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_n     <= bus.n;
            r_s     <= '0;
            r_cnt   <= '0;
            r_err   <= ~bus.n[0];
            r_n_err <= 1'b0;
          end
        end
        StIter: begin
          r_s   <= w_s_step;
          r_a   <= r_a >> 1;
          r_cnt <= r_cnt + 1'b1;
        end
        StFix: begin
          r_done <= 1'b1;
          if (r_err) begin
            r_result <= '0;
            r_n_err  <= 1'b1;
          end else begin
            r_result <= w_fix;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.result = r_result;
  assign bus.done   = r_done;
  assign bus.n_err  = r_n_err;

endmodule

// File: tb/tb_mont_mul_serial.sv
// Directed bench for mont_mul_serial with DATA_LENGTH=8, n=239
// (R mod n = 17, R^2 mod n = 50).
module tb_mont_mul_serial;

  localparam int unsigned DL = 8;

  logic clk;
  logic rst;

  int n_tests;
  int n_fail;

  mont_mul_serial_if #(.DATA_LENGTH(DL)) bus ();

  mont_mul_serial #(
    .DATA_LENGTH (DL),
    .CNT_W       (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch one operation; latency is counted in edges from the raise of start
  // (the acceptance edge is edge 1). Busy is sampled after every edge.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] in_,
                       output logic [7:0] ores, output logic oerr,
                       output int olat, output int obusy);
    @(posedge clk);
    #1;
    bus.a     = ia;
    bus.b     = ib;
    bus.n     = in_;
    bus.start = 1'b1;
    olat  = -1;
    obusy = 0;
    ores  = 'x;
    oerr  = 1'bx;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.busy) obusy++;
      if (bus.done) begin
        olat = e;
        ores = bus.result;
        oerr = bus.n_err;
        break;
      end
    end
  endtask

  logic [7:0] res;
  logic       err;
  int         lat;
  int         bsy;
  int         ndone;
  logic [7:0] hres;
  int         first;
  int         second;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.n     = '0;
    rst       = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_result", 32'(bus.result), 0);
    check("rst_n_err", 32'(bus.n_err), 0);
    #3 rst = 1'b0;

    // Into Montgomery domain: 5 * R mod 239 = 85
    do_op(8'd5, 8'd50, 8'd239, res, err, lat, bsy);
    check("to_dom_result", 32'(res), 85);
    check("to_dom_n_err", 32'(err), 0);
    check("to_dom_latency", 32'(lat), 10);
    check("to_dom_busy_cycles", 32'(bsy), 9);

    // Out of Montgomery domain
    do_op(8'd85, 8'd1, 8'd239, res, err, lat, bsy);
    check("from_dom_result", 32'(res), 5);
    check("from_dom_latency", 32'(lat), 10);

    // (-1)*(-1)*R^-1 = R^-1 mod 239 = 225
    do_op(8'd238, 8'd238, 8'd239, res, err, lat, bsy);
    check("rinv_result", 32'(res), 225);

    // R*R*R^-1 = R mod n = 17
    do_op(8'd17, 8'd17, 8'd239, res, err, lat, bsy);
    check("r_sq_result", 32'(res), 17);

    // R^2 * R^-1 = 17
    do_op(8'd50, 8'd1, 8'd239, res, err, lat, bsy);
    check("r2_out_result", 32'(res), 17);

    // Zero operand
    do_op(8'd0, 8'd123, 8'd239, res, err, lat, bsy);
    check("zero_a_result", 32'(res), 0);

    // Even modulus
    do_op(8'd5, 8'd50, 8'd240, res, err, lat, bsy);
    check("even_n_latency", 32'(lat), 2);
    check("even_n_err", 32'(err), 1);
    check("even_n_result", 32'(res), 0);
    check("even_n_busy_cycles", 32'(bsy), 1);

    // Next valid start clears n_err
    do_op(8'd5, 8'd50, 8'd239, res, err, lat, bsy);
    check("clear_err_n_err", 32'(err), 0);
    check("clear_err_result", 32'(res), 85);

    // Start pulses while busy (with other operands) are ignored
    @(posedge clk);
    #1;
    bus.a     = 8'd5;
    bus.b     = 8'd50;
    bus.n     = 8'd239;
    bus.start = 1'b1;
    ndone = 0;
    hres  = '0;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk);
      #1;
      bus.start = (e == 2 || e == 4 || e == 6);
      if (e == 2) begin
        bus.a = 8'd1;
        bus.b = 8'd1;
      end
      if (bus.done) begin
        ndone++;
        hres = bus.result;
      end
    end
    check("busy_start_done_count", 32'(ndone), 1);
    check("busy_start_result", 32'(hres), 85);

    // start held through done: back-to-back with no extra bubble
    @(posedge clk);
    #1;
    bus.a     = 8'd5;
    bus.b     = 8'd50;
    bus.n     = 8'd239;
    bus.start = 1'b1;
    first  = -1;
    second = -1;
    hres   = '0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        if (first < 0) begin
          first = e;
        end else begin
          second    = e;
          hres      = bus.result;
          bus.start = 1'b0;
          break;
        end
      end
    end
    bus.start = 1'b0;
    check("b2b_first_latency", 32'(first), 10);
    check("b2b_second_gap", 32'(second - first), 10);
    check("b2b_result", 32'(hres), 85);

    // Asynchronous reset mid-operation
    @(posedge clk);
    #1;
    bus.a     = 8'd5;
    bus.b     = 8'd50;
    bus.n     = 8'd239;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_done", 32'(bus.done), 0);
    check("midrst_result", 32'(bus.result), 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    ndone = 0;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 0);

    do_op(8'd5, 8'd50, 8'd239, res, err, lat, bsy);
    check("post_rst_result", 32'(res), 85);
    check("post_rst_latency", 32'(lat), 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
